invader_wave_ctrl: RTL and testbench

Sequences one invader formation of five columns through a game: spawn, march, descend, cleared and game over. It owns formation position, per-column hit points, alive mask, wave number and score. It consumes hit events from the projectile collision checker. Its position, alive and hp outputs drive the invader renderer and the collision logic.

---
 rtl/invader_wave_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_invader_wave_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/invader_wave_ctrl.sv
// Invader formation controller: sequences spawn, march, descend, cleared and
// game-over, and owns formation position, per-column hit points, wave and score.
module invader_wave_ctrl #(
  parameter int unsigned X_START     = 100,
  parameter int unsigned Y_START     = 10,
  parameter int unsigned X_MIN       = 95,
  parameter int unsigned X_MAX       = 390,
  parameter int unsigned DROP        = 5,
  parameter int unsigned Y_LIMIT     = 400,
  parameter int unsigned HP_INIT     = 2,
  parameter int unsigned POINTS      = 50,
  parameter int unsigned STEP_BASE   = 8,
  parameter int unsigned CLEAR_DELAY = 60
) (
  input  logic        dclk,
  input  logic        clr,
  input  logic        play,
  input  logic        move_tick,
  input  logic        hit_valid,
  input  logic [2:0]  hit_col,
  output logic [9:0]  enemy_x,
  output logic [9:0]  enemy_y,
  output logic [9:0]  hp,
  output logic [4:0]  alive,
  output logic [13:0] score,
  output logic [3:0]  wave,
  output logic [2:0]  state,
  output logic        hit_ack,
  output logic        game_over
);

  localparam int unsigned XW  = 10;
  localparam int unsigned YW  = 10;
  localparam int unsigned CW  = 5;
  localparam int unsigned SW  = 14;
  localparam int unsigned SSW = SW + 1;
  localparam int unsigned YSW = YW + 1;
  localparam int unsigned WW  = 4;
  localparam int unsigned TW  = 6;
  localparam logic [SW-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SPAWN   = 3'd1,
    S_MARCH   = 3'd2,
    S_DESCEND = 3'd3,
    S_CLEARED = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [2*CW-1:0] hp_q, hp_d;
  logic [CW-1:0]   alive_q, alive_d;
  logic [SW-1:0]   score_q, score_d;
  logic [WW-1:0]   wave_q, wave_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            ack_q, ack_d;
  logic            over_q, over_d;

  logic [TW-1:0]   step_last;
  logic [7:0]      alive_ext;
  logic            hit_ok;
  logic [SSW-1:0]  score_sum;
  logic [YSW-1:0]  y_sum;

  // Last tick index of a step; step period shrinks with wave, floored at one tick
  always_comb begin
    if (32'(wave_q) + 32'd1 >= STEP_BASE) step_last = '0;
    else                                  step_last = TW'(STEP_BASE - 32'(wave_q) - 32'd1);
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    hp_d      = hp_q;
    alive_d   = alive_q;
    score_d   = score_q;
    wave_d    = wave_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    alive_ext = {3'b000, alive_q};
    hit_ok    = (state_q == S_MARCH || state_q == S_DESCEND) && hit_valid &&
                (hit_col < 3'd5) && alive_ext[hit_col];
    ack_d     = hit_ok;
    score_sum = {1'b0, score_q} + SSW'(POINTS);
    y_sum     = {1'b0, y_q} + YSW'(DROP);

    unique case (state_q)
      S_IDLE: if (play) state_d = S_SPAWN;
      S_SPAWN: begin
        x_d     = XW'(X_START);
        y_d     = YW'(Y_START);
        hp_d    = {CW{2'(HP_INIT)}};
        alive_d = '1;
        dir_d   = 1'b0;
        cnt_d   = '0;
        state_d = S_MARCH;
      end
      S_MARCH: if (move_tick) begin
        if (cnt_q == step_last) begin
          cnt_d = '0;
          if (!dir_q && x_q < XW'(X_MAX))     x_d = x_q + XW'(1);
          else if (dir_q && x_q > XW'(X_MIN)) x_d = x_q - XW'(1);
          else                                state_d = S_DESCEND;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_DESCEND: begin
        y_d     = y_sum[YW-1:0];
        dir_d   = ~dir_q;
        state_d = (y_sum >= YSW'(Y_LIMIT)) ? S_OVER : S_MARCH;
      end
      S_CLEARED: if (move_tick) begin
        if (cnt_q == TW'(CLEAR_DELAY - 1)) begin
          cnt_d   = '0;
          state_d = S_SPAWN;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      S_OVER: ;
      default: state_d = S_IDLE;
    endcase

    // A hit drains hp first; a hit on an empty column kills it and scores
    for (int c = 0; c < CW; c++) begin
      if (hit_ok && hit_col == 3'(c)) begin
        if (hp_q[2*c +: 2] != 2'd0) begin
          hp_d[2*c +: 2] = hp_q[2*c +: 2] - 2'd1;
        end else begin
          alive_d[c] = 1'b0;
          score_d    = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SW-1:0];
        end
      end
    end

    // Wiping the formation wins over any movement outcome, including game over
    if ((state_q == S_MARCH || state_q == S_DESCEND) && alive_d == '0) begin
      state_d = S_CLEARED;
      cnt_d   = '0;
      if (wave_q != '1) wave_d = wave_q + WW'(1);
    end

    if (!play) begin
      state_d = S_IDLE;
      x_d     = XW'(X_START);
      y_d     = YW'(Y_START);
      hp_d    = '0;
      alive_d = '0;
      score_d = '0;
      wave_d  = '0;
      cnt_d   = '0;
      dir_d   = 1'b0;
      ack_d   = 1'b0;
    end

    over_d = (state_d == S_OVER);
  end

  always_ff @(posedge dclk) begin
    if (clr) begin
      state_q <= S_IDLE;
      x_q     <= XW'(X_START);
      y_q     <= YW'(Y_START);
      hp_q    <= '0;
      alive_q <= '0;
      score_q <= '0;
      wave_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ack_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hp_q    <= hp_d;
      alive_q <= alive_d;
      score_q <= score_d;
      wave_q  <= wave_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ack_q   <= ack_d;
      over_q  <= over_d;
    end
  end

  assign state     = state_q;
  assign enemy_x   = x_q;
  assign enemy_y   = y_q;
  assign hp        = hp_q;
  assign alive     = alive_q;
  assign score     = score_q;
  assign wave      = wave_q;
  assign hit_ack   = ack_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_invader_wave_ctrl.sv
// Scoreboard bench for invader_wave_ctrl: stimulus queues expectations, a
// negedge monitor pops and compares them and every hit_ack pulse.
module tb_invader_wave_ctrl;

  localparam int SEL_STATE = 0;
  localparam int SEL_X     = 1;
  localparam int SEL_Y     = 2;
  localparam int SEL_HP    = 3;
  localparam int SEL_ALIVE = 4;
  localparam int SEL_SCORE = 5;
  localparam int SEL_WAVE  = 6;
  localparam int SEL_ACK   = 7;
  localparam int SEL_GO    = 8;

  localparam int ST_IDLE = 0, ST_SPAWN = 1, ST_MARCH = 2, ST_DESCEND = 3,
                 ST_CLEARED = 4, ST_OVER = 5;

  typedef struct { int at; int sel; int val; string name; } exp_t;
  typedef struct { int hpv; int alv; int scv; } ack_t;

  logic        dclk = 1'b0;
  logic        clr, play, move_tick, hit_valid;
  logic [2:0]  hit_col;
  logic [9:0]  enemy_x, enemy_y, hp;
  logic [4:0]  alive;
  logic [13:0] score;
  logic [3:0]  wave;
  logic [2:0]  state;
  logic        hit_ack, game_over;

  exp_t exp_q[$];
  ack_t ack_q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  bit   drain = 1'b0;
  bit   drained = 1'b0;

  int   m_hp[5];
  int   m_alive = 0;
  int   m_score = 0;

  invader_wave_ctrl dut (
    .dclk(dclk), .clr(clr), .play(play), .move_tick(move_tick),
    .hit_valid(hit_valid), .hit_col(hit_col), .enemy_x(enemy_x),
    .enemy_y(enemy_y), .hp(hp), .alive(alive), .score(score), .wave(wave),
    .state(state), .hit_ack(hit_ack), .game_over(game_over)
  );

  always #5 dclk = ~dclk;
  always @(posedge dclk) cyc <= cyc + 1;

  function automatic int get(input int sel);
    case (sel)
      SEL_STATE: return int'(state);
      SEL_X:     return int'(enemy_x);
      SEL_Y:     return int'(enemy_y);
      SEL_HP:    return int'(hp);
      SEL_ALIVE: return int'(alive);
      SEL_SCORE: return int'(score);
      SEL_WAVE:  return int'(wave);
      SEL_ACK:   return int'(hit_ack);
      SEL_GO:    return int'(game_over);
      default:   return -1;
    endcase
  endfunction

  function automatic int pack_hp();
    int v = 0;
    for (int c = 0; c < 5; c++) v += m_hp[c] << (2 * c);
    return v;
  endfunction

  // Monitor: the only place counters move
  always @(negedge dclk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_total++;
      if (get(e.sel) == e.val) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, get(e.sel), e.val, cyc);
    end
    if (hit_ack) begin
      n_total++;
      if (ack_q.size() == 0) begin
        $display("FAIL unexpected_hit_ack: got ack with no accepted hit (cycle %0d)", cyc);
      end else begin
        ack_t a;
        a = ack_q.pop_front();
        if (int'(hp) == a.hpv && int'(alive) == a.alv && int'(score) == a.scv) n_pass++;
        else $display("FAIL hit_result: got hp=%0d alive=%0d score=%0d expected hp=%0d alive=%0d score=%0d",
                      hp, alive, score, a.hpv, a.alv, a.scv);
      end
    end
    if (drain && !drained) begin
      drained = 1'b1;
      n_total++;
      if (exp_q.size() == 0 && ack_q.size() == 0) n_pass++;
      else $display("FAIL leftover: got %0d checks and %0d acks pending expected 0", exp_q.size(), ack_q.size());
    end
  end

  task automatic step();
    @(posedge dclk);
    #1;
  endtask

  task automatic want(input int sel, input int val, input string name);
    exp_q.push_back('{cyc, sel, val, name});
  endtask

  task automatic model_spawn();
    for (int c = 0; c < 5; c++) m_hp[c] = 2;
    m_alive = 31;
  endtask

  task automatic want_reset(input string tag);
    want(SEL_STATE, ST_IDLE, {tag, "_state"});
    want(SEL_X, 100, {tag, "_x"});
    want(SEL_Y, 10, {tag, "_y"});
    want(SEL_HP, 0, {tag, "_hp"});
    want(SEL_ALIVE, 0, {tag, "_alive"});
    want(SEL_SCORE, 0, {tag, "_score"});
    want(SEL_WAVE, 0, {tag, "_wave"});
    want(SEL_ACK, 0, {tag, "_ack"});
    want(SEL_GO, 0, {tag, "_game_over"});
  endtask

  task automatic hit(input int col, input bit accept);
    hit_valid = 1'b1;
    hit_col   = 3'(col);
    if (accept) begin
      if (m_hp[col] > 0) m_hp[col]--;
      else begin
        m_alive &= ~(1 << col);
        m_score = (m_score + 50 > 16383) ? 16383 : m_score + 50;
      end
      ack_q.push_back('{pack_hp(), m_alive, m_score});
    end
    step();
    hit_valid = 1'b0;
  endtask

  task automatic wait_state(input int s, input int bound, input string name);
    int n = 0;
    while (int'(state) != s && n < bound) begin
      step();
      n++;
    end
    want(SEL_STATE, s, name);
  endtask

  task automatic clear_wave();
    for (int c = 0; c < 5; c++) repeat (3) hit(c, 1'b1);
    wait_state(ST_SPAWN, 100, "respawn");
    step();
    model_spawn();
  endtask

  initial begin
    clr = 1'b1; play = 1'b0; move_tick = 1'b0; hit_valid = 1'b0; hit_col = 3'd0;
    step(); step();
    want_reset("reset");

    // Spawn sequence
    clr = 1'b0; play = 1'b1;
    step(); want(SEL_STATE, ST_SPAWN, "spawn_state");
    step(); model_spawn();
    want(SEL_STATE, ST_MARCH, "march_state");
    want(SEL_X, 100, "spawn_x"); want(SEL_Y, 10, "spawn_y");
    want(SEL_ALIVE, 31, "spawn_alive"); want(SEL_HP, 682, "spawn_hp");

    // March right at period 8, descend at the right edge, then move left
    move_tick = 1'b1;
    repeat (7) step(); want(SEL_X, 100, "x_before_first_step");
    step();            want(SEL_X, 101, "x_first_step");
    repeat (289 * 8) step(); want(SEL_X, 390, "x_at_max"); want(SEL_STATE, ST_MARCH, "march_at_max");
    repeat (8) step();
    want(SEL_STATE, ST_DESCEND, "descend_state"); want(SEL_X, 390, "descend_x"); want(SEL_Y, 10, "descend_y_before");
    step(); want(SEL_STATE, ST_MARCH, "after_descend"); want(SEL_Y, 15, "y_after_descend");
    repeat (7) step(); want(SEL_X, 390, "x_hold_left");
    step();            want(SEL_X, 389, "x_first_left_step");

    // Column 2 takes three hits, then stray hits are ignored
    move_tick = 1'b0;
    repeat (3) hit(2, 1'b1);
    hit(2, 1'b0);
    want(SEL_ACK, 0, "dead_col_no_ack"); want(SEL_HP, 650, "dead_col_hp");
    want(SEL_ALIVE, 27, "dead_col_alive"); want(SEL_SCORE, 50, "dead_col_score");
    hit(6, 1'b0);
    want(SEL_ACK, 0, "bad_col_no_ack"); want(SEL_ALIVE, 27, "bad_col_alive");

    // Wipe the formation, wait out the clear delay, next wave at period 7
    for (int c = 0; c < 5; c++) if (c != 2) repeat (3) hit(c, 1'b1);
    want(SEL_STATE, ST_CLEARED, "cleared_state"); want(SEL_WAVE, 1, "wave_after_clear");
    want(SEL_SCORE, 250, "score_after_clear"); want(SEL_ALIVE, 0, "alive_after_clear");
    move_tick = 1'b1;
    repeat (59) step(); want(SEL_STATE, ST_CLEARED, "cleared_hold");
    step();             want(SEL_STATE, ST_SPAWN, "cleared_to_spawn");
    step(); model_spawn();
    want(SEL_STATE, ST_MARCH, "wave1_march"); want(SEL_X, 100, "wave1_x");
    want(SEL_HP, 682, "wave1_hp"); want(SEL_SCORE, 250, "wave1_score_kept");
    repeat (6) step(); want(SEL_X, 100, "wave1_x_hold");
    step();            want(SEL_X, 101, "wave1_period7");

    // Advance to wave 7 where the step period bottoms out at one tick
    for (int w = 1; w < 7; w++) clear_wave();
    want(SEL_WAVE, 7, "wave7"); want(SEL_SCORE, 1750, "wave7_score");

    // Last kill lands in the final descend: cleared wins over game over
    begin
      int n = 0;
      while (int'(enemy_y) != 395 && n < 40000) begin step(); n++; end
      want(SEL_Y, 395, "reach_y395");
    end
    for (int c = 0; c < 4; c++) repeat (3) hit(c, 1'b1);
    repeat (2) hit(4, 1'b1);
    wait_state(ST_DESCEND, 400, "final_descend");
    hit(4, 1'b1);
    want(SEL_STATE, ST_CLEARED, "kill_beats_over"); want(SEL_GO, 0, "kill_beats_over_go");
    want(SEL_WAVE, 8, "wave8"); want(SEL_SCORE, 2000, "score_2000"); want(SEL_Y, 400, "kill_descend_y");
    wait_state(ST_SPAWN, 100, "wave8_spawn");
    step(); model_spawn();

    // March all the way down to game over, which freezes everything
    wait_state(ST_OVER, 40000, "reach_over");
    want(SEL_X, 95, "over_x"); want(SEL_Y, 400, "over_y"); want(SEL_GO, 1, "over_game_over");
    want(SEL_SCORE, 2000, "over_score"); want(SEL_WAVE, 8, "over_wave");
    want(SEL_ALIVE, 31, "over_alive"); want(SEL_HP, 682, "over_hp");
    hit(0, 1'b0);
    repeat (3) step();
    want(SEL_STATE, ST_OVER, "frozen_state"); want(SEL_X, 95, "frozen_x");
    want(SEL_Y, 400, "frozen_y"); want(SEL_HP, 682, "frozen_hp"); want(SEL_GO, 1, "frozen_game_over");
    play = 1'b0;
    step(); m_score = 0;
    want_reset("play_low");

    // clr in the middle of a march restores every reset value
    play = 1'b1;
    step(); step(); model_spawn();
    want(SEL_STATE, ST_MARCH, "replay_march"); want(SEL_WAVE, 0, "replay_wave0");
    repeat (3) hit(0, 1'b1);
    want(SEL_SCORE, 50, "replay_score");
    repeat (4) step();
    clr = 1'b1;
    step(); m_score = 0;
    want_reset("clr_mid_march");
    clr = 1'b0; play = 1'b0; move_tick = 1'b0;

    step(); step();
    drain = 1'b1;
    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
